// File: rtl/lab3_dg_keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column drive, debounces a single
// key press and release, and presents the one-hot {row,col} word to the decoder.
module lab3_dg_keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [7:0] keypress,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [1:0]    idx, idx_d;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic [3:0]    row_oh, row_d;
    logic [3:0]    col_oh, col_d;
    logic [7:0]    kp_d;
    logic          valid_d, held_d;

    logic [3:0]    rs_meta, rs, nr, col_cur;
    logic [DW-1:0] dwell;
    logic          sample, one_low;

    // rows are asynchronous to clk; idle (pulled-up) value is all ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_meta <= 4'b1111;
            rs      <= 4'b1111;
        end else begin
            rs_meta <= rows;
            rs      <= rs_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) dwell <= '0;
        else        dwell <= sample ? '0 : dwell + 1'b1;
    end

    assign sample  = (dwell == DWELL_MAX);
    assign nr      = ~rs;
    assign one_low = (nr != 4'd0) && ((nr & (nr - 4'd1)) == 4'd0);
    assign col_cur = 4'b0001 << idx;
    assign cnt_inc = cnt + 1'b1;
    assign cols    = ~col_cur;

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        row_d   = row_oh;
        col_d   = col_oh;
        kp_d    = keypress;
        valid_d = 1'b0;
        held_d  = key_held;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (one_low) begin
                        row_d = nr;
                        col_d = col_cur;
                        if (DEBOUNCE_CNT <= 1) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            kp_d    = {nr, col_cur};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        idx_d = idx + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (nr == row_oh) begin
                        if (cnt_inc == CNT_MAX) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            kp_d    = {row_oh, col_oh};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        cnt_d   = '0;
                        idx_d   = idx + 2'd1;
                    end
                end
            end
            HELD: begin
                // only the latched row matters; other keys are ignored
                if (sample) begin
                    if ((rs & row_oh) != 4'd0) begin
                        if (cnt_inc == CNT_MAX) begin
                            state_d = SCAN;
                            cnt_d   = '0;
                            held_d  = 1'b0;
                            idx_d   = idx + 2'd1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            idx       <= 2'd0;
            cnt       <= '0;
            row_oh    <= 4'd0;
            col_oh    <= 4'd0;
            keypress  <= 8'h00;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            cnt       <= cnt_d;
            row_oh    <= row_d;
            col_oh    <= col_d;
            keypress  <= kp_d;
            key_valid <= valid_d;
            key_held  <= held_d;
        end
    end

endmodule

// File: tb/tb_lab3_dg_keypad_scanner.sv
// Directed bench for the keypad scanner with a column-driven keypad model.
module tb_lab3_dg_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] keypress;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys = 16'h0000;   // keys[4*row+col]

    int tests = 0;
    int fails = 0;
    int valid_cnt = 0;
    int cyc;
    logic [3:0] c0;

    lab3_dg_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .clk(clk), .reset(reset), .rows(rows), .cols(cols),
        .keypress(keypress), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !cols[c]) rows[r] = 1'b0;
    end

    always @(posedge clk) if (key_valid === 1'b1) valid_cnt++;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (key_valid !== 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_release(input int bound, output int n);
        n = 0;
        while (key_held !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        // reset state
        tick(2);
        chk("rst_cols", {4'h0, cols}, 8'h0E);
        chk("rst_keypress", keypress, 8'h00);
        chk("rst_valid", {7'd0, key_valid}, 8'h00);
        chk("rst_held", {7'd0, key_held}, 8'h00);

        // idle scan
        reset = 1'b1;
        tick(4); chk("scan_c1", {4'h0, cols}, 8'h0D);
        tick(4); chk("scan_c2", {4'h0, cols}, 8'h0B);
        tick(4); chk("scan_c3", {4'h0, cols}, 8'h07);
        tick(4); chk("scan_c0", {4'h0, cols}, 8'h0E);
        chk("idle_novalid", 8'(valid_cnt), 8'd0);
        chk("idle_keypress", keypress, 8'h00);

        // steady press row1/col2
        keys[4*1+2] = 1'b1;
        wait_valid(27, cyc);
        chk("p12_valid", {7'd0, key_valid}, 8'h01);
        chk("p12_keypress", keypress, 8'b0010_0100);
        chk("p12_held", {7'd0, key_held}, 8'h01);
        chk("p12_cols", {4'h0, cols}, 8'h0B);
        tick(1);
        chk("p12_pulse1", {7'd0, key_valid}, 8'h00);
        tick(8);
        chk("p12_frozen", {4'h0, cols}, 8'h0B);
        chk("p12_count", 8'(valid_cnt), 8'd1);
        keys = '0;
        wait_release(30, cyc);
        chk("p12_release", {7'd0, key_held}, 8'h00);
        chk("p12_kp_kept", keypress, 8'b0010_0100);

        // bounce: released in time for the second debounce sample
        keys[4*1+2] = 1'b1;
        tick(17);
        keys = '0;
        tick(6);
        chk("bounce_novalid", 8'(valid_cnt), 8'd1);
        chk("bounce_noheld", {7'd0, key_held}, 8'h00);
        keys[4*1+2] = 1'b1;
        wait_valid(40, cyc);
        chk("bounce_valid", {7'd0, key_valid}, 8'h01);
        chk("bounce_kp", keypress, 8'b0010_0100);
        tick(1);
        chk("bounce_count", 8'(valid_cnt), 8'd2);
        keys = '0;
        wait_release(30, cyc);
        chk("bounce_release", {7'd0, key_held}, 8'h00);

        // hold row0/col0, add row3/col1, release both
        keys[0] = 1'b1;
        wait_valid(40, cyc);
        chk("p00_valid", {7'd0, key_valid}, 8'h01);
        chk("p00_kp", keypress, 8'b0001_0001);
        tick(1);
        keys[4*3+1] = 1'b1;
        tick(20);
        chk("rollover_count", 8'(valid_cnt), 8'd3);
        chk("rollover_held", {7'd0, key_held}, 8'h01);
        chk("rollover_cols", {4'h0, cols}, 8'h0E);
        chk("rollover_kp", keypress, 8'b0001_0001);
        keys[4*3+1] = 1'b0;
        tick(4);
        keys[0] = 1'b0;
        wait_release(30, cyc);
        chk("p00_release", {7'd0, key_held}, 8'h00);
        chk("p00_rel_lat", {7'd0, (cyc >= 11 && cyc <= 14)}, 8'h01);
        chk("p00_kp_kept", keypress, 8'b0001_0001);
        tick(4);
        chk("p00_count", 8'(valid_cnt), 8'd3);

        // two keys in column 3
        keys[4*0+3] = 1'b1;
        keys[4*2+3] = 1'b1;
        tick(40);
        chk("dual_novalid", 8'(valid_cnt), 8'd3);
        chk("dual_noheld", {7'd0, key_held}, 8'h00);
        c0 = cols;
        tick(4);
        chk("dual_scanning", {4'h0, cols}, {4'h0, c0[2:0], c0[3]});
        keys = '0;
        tick(10);

        // reset while held on row2/col1, then re-accept
        keys[4*2+1] = 1'b1;
        wait_valid(40, cyc);
        chk("p21_kp", keypress, 8'b0100_0010);
        tick(6);
        chk("p21_held", {7'd0, key_held}, 8'h01);
        reset = 1'b0;
        #1;
        chk("mid_rst_cols", {4'h0, cols}, 8'h0E);
        chk("mid_rst_kp", keypress, 8'h00);
        chk("mid_rst_held", {7'd0, key_held}, 8'h00);
        chk("mid_rst_valid", {7'd0, key_valid}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        wait_valid(40, cyc);
        chk("reacc_valid", {7'd0, key_valid}, 8'h01);
        chk("reacc_kp", keypress, 8'b0100_0010);
        chk("reacc_held", {7'd0, key_held}, 8'h01);
        tick(1);
        chk("reacc_count", 8'(valid_cnt), 8'd5);
        keys = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
